shift_left_sequencer: RTL and testbench
=======================================

# shift_left_sequencer

Sequential controller that drives a one-position left-shift datapath to perform a multi-position logical left shift over several clock cycles. It accepts an operand and shift amount through a valid/ready handshake and applies one single-bit shift per cycle. It holds the result until the consumer accepts it. It sits between the operand source (register file or test stimulus) and any consumer of shifted values, and replaces a wide combinational barrel shifter with the existing narrow shift stage.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- AMT_W, 3, shift-amount field width; amounts 0 to 2^AMT_W−1
- clk  input  1  rising-edge clock; one clock domain
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  operand/amount presented
- in_ready  output  1  sequencer can accept; high only in IDLE
- operand  input  WIDTH  value to shift
- amount  input  AMT_W  number of positions to shift left
- out_valid  output  1  result is valid and held; high only in DONE
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  shifted value, zero-filled from LSB
- busy  output  1  high in SHIFT or DONE
- ovf  output  1  sticky: a 1 was shifted out of the MSB (see Configuration)

## Operation
- State machine with three states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Datapath registers:
  - data (WIDTH): holds the operand as it is shifted.
  - cnt (AMT_W): remaining shifts.
  - ovf_r: sticky overflow flag.
- IDLE:
  - in_ready=1.
  - On in_valid, the handshake completes on that clock edge:
    - data←operand; ovf_r←0.
    - cnt←min(amount, WIDTH). Amounts ≥ WIDTH saturate to WIDTH, so the result is zero after WIDTH cycles.
    - If the saturated count is 0, go to DONE; otherwise go to SHIFT.
- SHIFT: on each edge:
  - data←{data[WIDTH−2:0],1'b0}.
  - ovf_r←ovf_r | data[WIDTH−1].
  - cnt←cnt−1.
  - When cnt==1, go to DONE on the same edge.
  - in_valid is ignored, and in_ready=0.
- DONE:
  - out_valid=1 and result=data, both held stable.
  - When out_ready=1, go to IDLE on that edge.
  - No back-to-back accept: in_ready rises one cycle after the result handshake.
- result always reflects data. Consumers sample it only while out_valid=1.
- busy = (state ≠ IDLE).
- Reset mid-operation: any state returns to IDLE asynchronously. An in-flight shift is discarded, and no out_valid pulse is produced.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, busy=0, ovf=0.
  - result=0, with data cleared.
  - state=IDLE, cnt=0.
- Latency: let k = min(amount, WIDTH), with the accept edge as E0.
  - out_valid rises after edge E0+k.
  - k=0: out_valid is high the cycle after accept.
  - k=4 at WIDTH=4: four cycles.
- Throughput: one operation per k+2 cycles minimum. This assumes out_ready is held high: accept, k shifts, one DONE cycle, then IDLE.
- out_valid stays high with result stable indefinitely while out_ready=0.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- Macro SHIFT_SEQ_OVF_EN.
- Defined:
  - ovf_r logic is compiled in.
  - ovf reports whether any 1 bit was shifted out, valid while out_valid=1.
  - ovf is cleared on accept and on reset.
- Undefined:
  - ovf_r logic is omitted.
  - ovf is tied to constant 0.
  - Shift behaviour and timing are otherwise identical.

## Test plan
- Reset then idle: assert reset for 2 cycles, then release → in_ready=1, out_valid=0, busy=0, result=0, ovf=0.
- Basic shift: operand=4'b0011, amount=2, out_ready=1 → out_valid rises exactly 2 edges after accept, result=4'b1100, ovf=0.
- Zero and saturation cases:
  - amount=0, operand=4'b1011 → result=4'b1011 the cycle after accept.
  - amount=7, operand=4'b1111 → result=4'b0000 after 4 shift cycles; ovf=1 with the macro, 0 without.
- Backpressure:
  - operand=4'b0101, amount=1, out_ready held 0 for 5 cycles → result=4'b1010 stable and out_valid=1 throughout.
  - in_valid pulses during SHIFT/DONE are ignored.
  - Raising out_ready returns the block to IDLE on the next edge.
- Reset mid-operation: operand=4'b0001, amount=3, assert reset during the second shift cycle → immediate IDLE, no out_valid pulse. A subsequent operand=4'b0001, amount=3 yields result=4'b1000.
- Exhaustive sweep: all 16 operands × amounts 0–7 → result == (operand << amount) truncated to 4 bits. Latency equals min(amount,4), and ovf matches the reference model when SHIFT_SEQ_OVF_EN is defined.

Source files
------------

// File: rtl/shift_left_sequencer.sv
// shift_left_sequencer
//   Multi-cycle logical left shifter. Accepts an operand and shift amount
//   through a valid/ready handshake, then shifts one bit position per clock.
//   The result is held until the consumer takes it. This replaces a wide
//   barrel shifter with a single-bit shift stage.
//
//   Optional feature: define SHIFT_SEQ_OVF_EN to compile in the sticky
//   overflow flag. When the macro is undefined, ovf is tied to 0.
//
// Parameters
//   WIDTH : operand/result width (>= 2)
//   AMT_W : shift-amount width; amounts 0 .. 2^AMT_W-1
// Ports
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high reset
//   in_valid  : operand/amount presented
//   in_ready  : sequencer can accept (IDLE only)
//   operand   : value to shift
//   amount    : number of positions to shift left
//   out_valid : result valid and held (DONE only)
//   out_ready : consumer accepts result
//   result    : shifted value, zero-filled from the LSB
//   busy      : high in SHIFT or DONE
//   ovf       : sticky flag, set when a 1 was shifted out of the MSB
module shift_left_sequencer #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand,
   input  logic [AMT_W-1:0] amount,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             ovf
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] data;
   logic [AMT_W-1:0] cnt;
   logic [AMT_W-1:0] amt_sat;

   // Amounts at or beyond WIDTH are clamped to WIDTH shifts. This leaves the
   // result all zeros and lets every bit pass through the MSB, so the
   // overflow flag is still accurate. If WIDTH exceeds the largest amount,
   // the clamp never fires, so truncating WIDTH to AMT_W bits is safe.
   always_comb begin
      amt_sat = amount;
      if (32'(amount) >= WIDTH) amt_sat = AMT_W'(WIDTH);
   end

   // The handshake/status outputs are registered next to the state, so no
   // input reaches an output combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         data      <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data     <= operand;
                  cnt      <= amt_sat;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (amt_sat == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               data <= {data[WIDTH-2:0], 1'b0};
               cnt  <= cnt - 1'b1;
               // The last shift lands on the same edge that enters DONE.
               if (cnt == AMT_W'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               // The return to IDLE takes one edge, so a new accept cannot
               // share an edge with the result handshake.
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign result = data;

`ifdef SHIFT_SEQ_OVF_EN
   logic ovf_r;

   // The flag is cleared on accept and picks up the MSB before every shift.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_r <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         ovf_r <= 1'b0;
      end else if (state == SHIFT) begin
         ovf_r <= ovf_r | data[WIDTH-1];
      end
   end

   assign ovf = ovf_r;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_shift_left_sequencer.sv
// tb_shift_left_sequencer
//   Directed self-checking bench for shift_left_sequencer (WIDTH=4, AMT_W=3).
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Expected ovf follows SHIFT_SEQ_OVF_EN.
module tb_shift_left_sequencer;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] operand;
   logic [2:0] amount;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] result;
   logic       busy;
   logic       ovf;

   int n_checks = 0;
   int n_fail   = 0;

   shift_left_sequencer #(.WIDTH(4), .AMT_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operand   (operand),
      .amount    (amount),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef SHIFT_SEQ_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   // Called at a falling edge with in_ready high. Returns at the falling
   // edge right after the accept edge.
   task automatic do_accept(input logic [3:0] op, input logic [2:0] amt);
      in_valid = 1'b1;
      operand  = op;
      amount   = amt;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Counts edges after the accept edge until out_valid is seen. The count
   // is capped at 20; a timeout returns -1.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      in_valid = 1'b0; operand = 4'h0; amount = 3'd0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, busy, ovf} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_flags: got rdy/vld/busy/ovf=%b expected 1000",
                  {in_ready, out_valid, busy, ovf});
      end
      n_checks++;
      if (result !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_result: got %b expected 0000", result);
      end
   endtask

   task automatic test_basic;
      int lat;
      out_ready = 1'b1;
      do_accept(4'b0011, 3'd2);
      wait_done(lat);
      n_checks++;
      if (lat !== 2) begin
         n_fail++; $display("FAIL basic_latency: got %0d expected 2", lat);
      end
      n_checks++;
      if (result !== 4'b1100 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_result: got %b ovf=%b expected 1100 ovf=0", result, ovf);
      end
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL basic_idle: got rdy/vld/busy=%b expected 100",
                  {in_ready, out_valid, busy});
      end
   endtask

   task automatic test_zero_sat;
      int lat;
      out_ready = 1'b1;
      do_accept(4'b1011, 3'd0);
      n_checks++;
      if (out_valid !== 1'b1 || result !== 4'b1011) begin
         n_fail++;
         $display("FAIL zero_amount: got vld=%b res=%b expected vld=1 res=1011",
                  out_valid, result);
      end
      @(negedge clk);
      do_accept(4'b1111, 3'd7);
      wait_done(lat);
      n_checks++;
      if (lat !== 4) begin
         n_fail++; $display("FAIL sat_latency: got %0d expected 4", lat);
      end
      n_checks++;
      if (result !== 4'b0000 || ovf !== OVF_ON) begin
         n_fail++;
         $display("FAIL sat_result: got %b ovf=%b expected 0000 ovf=%b", result, ovf, OVF_ON);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      int lat;
      out_ready = 1'b0;
      do_accept(4'b0101, 3'd1);
      // This pulse arrives during SHIFT and must not be taken as a new accept.
      in_valid = 1'b1; operand = 4'b1111; amount = 3'd3;
      wait_done(lat);
      n_checks++;
      if (lat !== 1) begin
         n_fail++; $display("FAIL bp_latency: got %0d expected 1", lat);
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         operand  = 4'(i + 6);
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || result !== 4'b1010 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got vld=%b res=%b rdy=%b busy=%b expected 1 1010 0 1",
                     i, out_valid, result, in_ready, busy);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL bp_release: got rdy/vld/busy=%b expected 100",
                  {in_ready, out_valid, busy});
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      bit seen;
      out_ready = 1'b1;
      do_accept(4'b0001, 3'd3);
      @(posedge clk);        // first shift edge
      @(negedge clk);        // inside the second shift cycle
      reset = 1'b1;
      #1;
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b100 || result !== 4'h0) begin
         n_fail++;
         $display("FAIL midreset_async: got rdy/vld/busy=%b res=%b expected 100 0000",
                  {in_ready, out_valid, busy}, result);
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL midreset_no_pulse: got out_valid pulse expected none");
      end
      do_accept(4'b0001, 3'd3);
      wait_done(lat);
      n_checks++;
      if (lat !== 3 || result !== 4'b1000) begin
         n_fail++;
         $display("FAIL midreset_rerun: got lat=%0d res=%b expected 3 1000", lat, result);
      end
      @(negedge clk);
   endtask

   task automatic test_sweep;
      int lat, exp_lat;
      logic [15:0] wide;
      logic exp_ovf;
      for (int op = 0; op < 16; op++) begin
         for (int amt = 0; amt < 8; amt++) begin
            wide    = 16'(op) << amt;
            exp_ovf = OVF_ON & (|wide[15:4]);
            exp_lat = (amt > 4) ? 4 : amt;
            out_ready = 1'b0;
            n_checks++;
            if (in_ready !== 1'b1) begin
               n_fail++; $display("FAIL sweep_ready op=%0d amt=%0d: got 0 expected 1", op, amt);
            end
            do_accept(4'(op), 3'(amt));
            wait_done(lat);
            n_checks++;
            if (lat !== exp_lat || result !== wide[3:0] || ovf !== exp_ovf) begin
               n_fail++;
               $display("FAIL sweep op=%0d amt=%0d: got lat=%0d res=%b ovf=%b expected %0d %b %b",
                        op, amt, lat, result, ovf, exp_lat, wide[3:0], exp_ovf);
            end
            out_ready = 1'b1;
            @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_zero_sat;
      test_backpressure;
      test_reset_mid;
      test_sweep;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
